// File: rtl/pid_controller_mc.sv
// Time-multiplexed multi-channel PID controller: per-channel integrator/derivative state,
// per-sample gains and limits, clamping anti-windup, fixed 4-clock latency at one sample per clock.
module pid_controller_mc #(
    parameter int N_CH      = 4,
    parameter int IN_W      = 27,
    parameter int IN_FRAC   = 25,
    parameter int COEF_W    = 27,
    parameter int COEF_FRAC = 26,
    parameter int OUT_W     = 16,
    parameter int OUT_FRAC  = 15,
    parameter int ACC_FRAC  = 27,
    parameter int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              clear_ch_valid,
    input  logic [CH_W-1:0]   clear_ch,
    input  logic              in_valid,
    input  logic [CH_W-1:0]   in_ch,
    input  logic [IN_W-1:0]   setpoint,
    input  logic [IN_W-1:0]   meas,
    input  logic [COEF_W-1:0] kp,
    input  logic [COEF_W-1:0] ki,
    input  logic [COEF_W-1:0] kd,
    input  logic              hold_integral,
    input  logic [OUT_W-1:0]  out_min,
    input  logic [OUT_W-1:0]  out_max,
    output logic              out_valid,
    output logic [CH_W-1:0]   out_ch,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_saturated
);
    localparam int STAGES = 4;
    localparam int EW     = IN_W + 1;
    localparam int DW     = IN_W + 2;
    localparam int MW     = COEF_W + DW;
    localparam int SH     = COEF_FRAC + IN_FRAC - ACC_FRAC;
    localparam int AW     = MW - SH + 2;
    localparam int SW     = AW + 2;
    localparam int LSH    = ACC_FRAC - OUT_FRAC;

    logic              live, in_ok;
    logic [STAGES:1]   vld_pipe;

    logic [CH_W-1:0]          s1_ch, s2_ch, s3_ch;
    logic signed [EW-1:0]     s1_e, s2_e, s3_e;
    logic signed [COEF_W-1:0] s1_kp, s1_ki, s1_kd, s2_kd;
    logic                     s1_hold, s2_hold, s3_isat;
    logic signed [OUT_W-1:0]  s1_min, s1_max, s2_min, s2_max, s3_min, s3_max;
    logic signed [AW-1:0]     s2_p, s2_ii, s3_p, s3_inew, s3_d;

    logic signed [AW-1:0]     integ  [N_CH];
    logic signed [EW-1:0]     prev_e [N_CH];
    logic [N_CH-1:0]          primed;

    assign live  = reset && enable;
    assign in_ok = in_valid && ({1'b0, in_ch} < (CH_W+1)'(N_CH));

    always_ff @(posedge clk) begin
        if (!live) vld_pipe <= '0;
        else       vld_pipe <= {vld_pipe[STAGES-1:1], in_ok};
    end

    always_ff @(posedge clk) begin
        s1_ch   <= in_ch;
        s1_e    <= EW'($signed(setpoint)) - EW'($signed(meas));
        s1_kp   <= kp;
        s1_ki   <= ki;
        s1_kd   <= kd;
        s1_hold <= hold_integral;
        s1_min  <= out_min;
        s1_max  <= out_max;
    end

    logic signed [MW-1:0] p_full, ii_full, d_full;
    assign p_full  = MW'(s1_kp) * MW'(s1_e);
    assign ii_full = MW'(s1_ki) * MW'(s1_e);

    always_ff @(posedge clk) begin
        s2_ch   <= s1_ch;
        s2_e    <= s1_e;
        s2_p    <= AW'(p_full >>> SH);
        s2_ii   <= AW'(ii_full >>> SH);
        s2_kd   <= s1_kd;
        s2_hold <= s1_hold;
        s2_min  <= s1_min;
        s2_max  <= s1_max;
    end

    // State is read here only; a same-channel sample one stage ahead has not committed yet,
    // so its results are forwarded instead of the stored values.
    logic                 byp, cur_primed, isat;
    logic signed [AW-1:0] cur_integ, lim_lo, lim_hi, isum, inew;
    logic signed [EW-1:0] cur_prev;
    logic signed [DW-1:0] de;

    always_comb begin
        byp        = vld_pipe[3] && (s3_ch == s2_ch);
        cur_integ  = byp ? s3_inew : integ[s2_ch];
        cur_prev   = byp ? s3_e : prev_e[s2_ch];
        cur_primed = byp || primed[s2_ch];
        de         = cur_primed ? DW'(s2_e) - DW'(cur_prev) : '0;
        lim_lo     = AW'(s2_min) <<< LSH;
        lim_hi     = AW'(s2_max) <<< LSH;
        isum       = cur_integ + s2_ii;
        inew       = isum;
        isat       = 1'b0;
        if (s2_hold) begin
            inew = cur_integ;
        end else if (isum > lim_hi) begin
            inew = lim_hi;
            isat = 1'b1;
        end else if (isum < lim_lo) begin
            inew = lim_lo;
            isat = 1'b1;
        end
    end

    assign d_full = MW'(s2_kd) * MW'(de);

    always_ff @(posedge clk) begin
        s3_ch   <= s2_ch;
        s3_e    <= s2_e;
        s3_p    <= s2_p;
        s3_inew <= inew;
        s3_isat <= isat;
        s3_d    <= AW'(d_full >>> SH);
        s3_min  <= s2_min;
        s3_max  <= s2_max;
    end

    logic signed [SW-1:0] sum, y, omin, omax;
    logic                 osat;

    always_comb begin
        omin = SW'(s3_min);
        omax = SW'(s3_max);
        sum  = SW'(s3_p) + SW'(s3_inew) + SW'(s3_d);
        y    = sum >>> LSH;
        osat = s3_isat;
        if (y > omax) begin
            y    = omax;
            osat = 1'b1;
        end else if (y < omin) begin
            y    = omin;
            osat = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!live) begin
            out_ch        <= '0;
            out_data      <= '0;
            out_saturated <= 1'b0;
        end else if (vld_pipe[3]) begin
            out_ch        <= s3_ch;
            out_data      <= OUT_W'(y);
            out_saturated <= osat;
        end
    end

    assign out_valid = vld_pipe[STAGES];

    // A clear coinciding with a commit to the same channel wins.
    always_ff @(posedge clk) begin
        if (!live) begin
            for (int c = 0; c < N_CH; c++) begin
                integ[c]  <= '0;
                prev_e[c] <= '0;
            end
            primed <= '0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (vld_pipe[3] && s3_ch == CH_W'(c)) begin
                    integ[c]  <= s3_inew;
                    prev_e[c] <= s3_e;
                    primed[c] <= 1'b1;
                end
                if (clear_ch_valid && clear_ch == CH_W'(c)) begin
                    integ[c]  <= '0;
                    prev_e[c] <= '0;
                    primed[c] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_pid_controller_mc.sv
// Scoreboard bench for pid_controller_mc: an in-order arithmetic model predicts each result
// at issue time; a negedge monitor pops and compares whenever out_valid is seen.
module tb_pid_controller_mc;
    localparam int N_CH = 4;
    localparam int SH   = 24;
    localparam int LSH  = 12;
    localparam longint MN = -32768;
    localparam longint MX = 32767;
    localparam longint C_HALF = 64'sd33554432;
    localparam longint C_QTR  = 64'sd16777216;
    localparam longint E_QTR  = 64'sd8388608;
    localparam longint E_HALF = 64'sd16777216;

    logic        clk = 1'b0;
    logic        reset, enable, clear_ch_valid, in_valid, hold_integral;
    logic [1:0]  clear_ch, in_ch, out_ch;
    logic [26:0] setpoint, meas, kp, ki, kd;
    logic [15:0] out_min, out_max, out_data;
    logic        out_valid, out_saturated;

    pid_controller_mc dut (
        .clk(clk), .reset(reset), .enable(enable),
        .clear_ch_valid(clear_ch_valid), .clear_ch(clear_ch),
        .in_valid(in_valid), .in_ch(in_ch), .setpoint(setpoint), .meas(meas),
        .kp(kp), .ki(ki), .kd(kd), .hold_integral(hold_integral),
        .out_min(out_min), .out_max(out_max),
        .out_valid(out_valid), .out_ch(out_ch), .out_data(out_data), .out_saturated(out_saturated)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0]  ch;
        logic [15:0] data;
        logic        sat;
        int          due;
    } exp_t;

    exp_t q[$];
    exp_t mon_x;
    int   checks = 0;
    int   errors = 0;
    bit   expect_idle = 1'b1;
    bit   final_chk = 1'b0;

    longint m_integ [N_CH];
    longint m_prev  [N_CH];
    bit     m_primed[N_CH];

    always @(negedge clk) begin
        if (q.size() > 0 && q[0].due < cyc) begin
            mon_x = q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_out ch=%0d due=%0d now=%0d", mon_x.ch, mon_x.due, cyc);
        end
        if (expect_idle) begin
            checks++;
            if (out_valid !== 1'b0 || out_ch !== 2'd0 || out_data !== 16'h0 || out_saturated !== 1'b0) begin
                errors++;
                $display("FAIL idle_state got v=%b ch=%0d data=%h sat=%b, want all zero",
                         out_valid, out_ch, out_data, out_saturated);
            end
        end
        if (out_valid === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out got ch=%0d data=%h at cyc=%0d", out_ch, out_data, cyc);
            end else begin
                mon_x = q.pop_front();
                if (out_ch !== mon_x.ch || out_data !== mon_x.data || out_saturated !== mon_x.sat ||
                    cyc != mon_x.due) begin
                    errors++;
                    $display("FAIL result got ch=%0d data=%h sat=%b cyc=%0d want ch=%0d data=%h sat=%b cyc=%0d",
                             out_ch, out_data, out_saturated, cyc, mon_x.ch, mon_x.data, mon_x.sat, mon_x.due);
                end
            end
        end
        if (final_chk) begin
            checks++;
            if (q.size() != 0) begin
                errors++;
                $display("FAIL drain got %0d pending, want 0", q.size());
            end
        end
    end

    function automatic longint rnd_s(input int w);
        int r;
        r = int'($urandom);
        return longint'(r >>> (32 - w));
    endfunction

    task automatic model_clear();
        for (int c = 0; c < N_CH; c++) begin
            m_integ[c]  = 0;
            m_prev[c]   = 0;
            m_primed[c] = 1'b0;
        end
    endtask

    // In-order PID step in plain scaled-integer arithmetic.
    task automatic model_step(input int ch, input longint sp, input longint ms, input longint gp,
                              input longint gi, input longint gd, input bit hold,
                              input longint mn, input longint mx,
                              output longint y, output bit sat);
        longint e, de, p, ii, d, inew;
        e    = sp - ms;
        de   = m_primed[ch] ? e - m_prev[ch] : 0;
        p    = (gp * e) >>> SH;
        ii   = (gi * e) >>> SH;
        d    = (gd * de) >>> SH;
        sat  = 1'b0;
        inew = m_integ[ch];
        if (!hold) begin
            inew = m_integ[ch] + ii;
            if (inew > (mx <<< LSH)) begin inew = mx <<< LSH; sat = 1'b1; end
            else if (inew < (mn <<< LSH)) begin inew = mn <<< LSH; sat = 1'b1; end
        end
        y = (p + inew + d) >>> LSH;
        if (y > mx) begin y = mx; sat = 1'b1; end
        else if (y < mn) begin y = mn; sat = 1'b1; end
        m_integ[ch]  = inew;
        m_prev[ch]   = e;
        m_primed[ch] = 1'b1;
    endtask

    // When use_x is set the literal expected result replaces the model's prediction.
    task automatic issue(input int ch, input longint sp, input longint ms, input longint gp,
                         input longint gi, input longint gd, input bit hold,
                         input longint mn, input longint mx,
                         input bit use_x, input logic [15:0] xd, input bit xs);
        exp_t   x;
        longint y;
        bit     s;
        @(posedge clk);
        #1;
        model_step(ch, sp, ms, gp, gi, gd, hold, mn, mx, y, s);
        in_valid       = 1'b1;
        clear_ch_valid = 1'b0;
        in_ch          = 2'(ch);
        setpoint       = sp[26:0];
        meas           = ms[26:0];
        kp             = gp[26:0];
        ki             = gi[26:0];
        kd             = gd[26:0];
        hold_integral  = hold;
        out_min        = mn[15:0];
        out_max        = mx[15:0];
        x.ch   = 2'(ch);
        x.data = use_x ? xd : y[15:0];
        x.sat  = use_x ? xs : s;
        x.due  = cyc + 4;
        q.push_back(x);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        in_valid       = 1'b0;
        clear_ch_valid = 1'b0;
    endtask

    task automatic drain();
        repeat (6) idle();
    endtask

    initial begin
        longint a, b, t, sp;
        logic [15:0] x2 [3];
        reset = 1'b0; enable = 1'b1; clear_ch_valid = 1'b0; clear_ch = 2'd0;
        in_valid = 1'b0; in_ch = 2'd0; setpoint = '0; meas = '0;
        kp = '0; ki = '0; kd = '0; hold_integral = 1'b0;
        out_min = 16'h8000; out_max = 16'h7FFF;
        model_clear();
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        #1 expect_idle = 1'b0;

        issue(0, E_QTR, 0, C_HALF, 0, 0, 1'b0, MN, MX, 1'b1, 16'h1000, 1'b0);

        x2[0] = 16'h1000; x2[1] = 16'h2000; x2[2] = 16'h3000;
        for (int i = 0; i < 3; i++)
            issue(1, E_HALF, 0, 0, C_QTR, 0, 1'b0, MN, MX, 1'b1, x2[i], 1'b0);

        x2[2] = 16'h2000;
        for (int i = 0; i < 3; i++)
            issue(3, E_HALF, 0, 0, C_QTR, 0, 1'b0, MN, 64'sd8192, 1'b1, x2[i], i == 2);
        issue(3, 0, E_HALF, 0, C_QTR, 0, 1'b0, MN, 64'sd8192, 1'b1, 16'h1000, 1'b0);

        issue(2, E_QTR, 0, 0, 0, C_HALF, 1'b0, MN, MX, 1'b1, 16'h0000, 1'b0);
        issue(2, E_HALF, 0, 0, 0, C_HALF, 1'b0, MN, MX, 1'b1, 16'h1000, 1'b0);
        drain();
        @(posedge clk);
        #1 in_valid = 1'b0; clear_ch_valid = 1'b1; clear_ch = 2'd2;
        m_integ[2] = 0; m_prev[2] = 0; m_primed[2] = 1'b0;
        issue(2, E_HALF, 0, 0, 0, C_HALF, 1'b0, MN, MX, 1'b1, 16'h0000, 1'b0);
        drain();

        @(posedge clk);
        #1 enable = 1'b0; in_valid = 1'b0;
        @(posedge clk);
        #1 enable = 1'b1; expect_idle = 1'b1;
        model_clear();
        @(negedge clk);
        #1 expect_idle = 1'b0;

        for (int i = 0; i < 4; i++) begin
            issue(0, E_HALF, 0, 0, C_QTR, 0, 1'b0, MN, MX, 1'b1, 16'((i + 1) * 4096), 1'b0);
            issue(1, 0, E_HALF, 0, C_QTR, 0, 1'b0, MN, MX, 1'b1, 16'(65536 - (i + 1) * 4096), 1'b0);
        end
        for (int i = 0; i < 4; i++)
            issue(0, E_HALF, 0, 0, C_QTR, 0, 1'b0, MN, MX, 1'b1,
                  (i == 3) ? 16'h7FFF : 16'((i + 5) * 4096), i == 3);
        drain();

        for (int i = 0; i < 3; i++)
            issue(i, E_HALF, 0, C_HALF, C_QTR, C_HALF, 1'b0, MN, MX, 1'b0, 16'h0, 1'b0);
        @(posedge clk);
        #1 in_valid = 1'b0; reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1; q.delete(); model_clear(); expect_idle = 1'b1;
        @(negedge clk);
        #1 expect_idle = 1'b0;
        issue(0, E_QTR, 0, C_HALF, 0, 0, 1'b0, MN, MX, 1'b1, 16'h1000, 1'b0);

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(9) < 7) begin
                a = MN; b = MX;
                if ($urandom_range(1) == 1) begin
                    a = rnd_s(16); b = rnd_s(16);
                    if (a > b) begin t = a; a = b; b = t; end
                end
                sp = ($urandom_range(7) == 0) ? rnd_s(27) : rnd_s(24);
                issue($urandom_range(N_CH - 1), sp, rnd_s(24),
                      rnd_s(27) >>> $urandom_range(4), rnd_s(27) >>> $urandom_range(4),
                      rnd_s(27) >>> $urandom_range(4), $urandom_range(4) == 0, a, b,
                      1'b0, 16'h0, 1'b0);
            end else begin
                idle();
            end
        end

        for (int w = 0; w < 20 && q.size() > 0; w++) idle();
        final_chk = 1'b1;
        @(negedge clk);
        #1 final_chk = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
